// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - round-robin time-sharing of one external ALU between two requesters
//
// Ports:
//   clk, rst_n              clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready     per-requester request handshake; ready only in IDLE
//   req{0,1}_a/_b/_op/_cin  requester operands, op code and carry-in
//   rsp_valid/rsp_ready     one-hot response handshake to the granted requester
//   rsp_f, rsp_flags        captured ALU result and {cout, v, z}
//   alu_a/_b/_c/_cin        registered drive to the external ALU
//   alu_f/_cout/_v/_z       external ALU result and flags
//   busy                    high whenever the controller is not IDLE
//   op_count, op_count_sel  completed-op counter and per-requester toggle bits,
//                           present only when ALU_SHARE_OPCOUNT_EN is defined
module alu_share_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [1:0]   req_valid,
  output logic [1:0]   req_ready,
  input  logic [N-1:0] req0_a,
  input  logic [N-1:0] req0_b,
  input  logic [2:0]   req0_op,
  input  logic         req0_cin,
  input  logic [N-1:0] req1_a,
  input  logic [N-1:0] req1_b,
  input  logic [2:0]   req1_op,
  input  logic         req1_cin,
  output logic [1:0]   rsp_valid,
  input  logic [1:0]   rsp_ready,
  output logic [N-1:0] rsp_f,
  output logic [2:0]   rsp_flags,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  output logic [2:0]   alu_c,
  output logic         alu_cin,
  input  logic [N-1:0] alu_f,
  input  logic         alu_cout,
  input  logic         alu_v,
  input  logic         alu_z,
  output logic         busy
`ifdef ALU_SHARE_OPCOUNT_EN
  ,
  output logic [15:0]  op_count,
  output logic [1:0]   op_count_sel
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic last_grant;   // requester granted most recently; loses the next tie
  logic grant_id;     // requester owning the operation in flight
  logic grant;        // combinational winner while IDLE
  logic grant_any;
  logic req_fire;
  logic rsp_fire;

  // Next-state, grant and handshake decode
  always_comb begin
    state_nxt = state;
    req_ready = 2'b00;
    req_fire  = 1'b0;
    rsp_fire  = 1'b0;
    grant_any = |req_valid;
    // A lone requester wins outright; on a tie the one not served last wins.
    if (req_valid == 2'b11) begin
      grant = ~last_grant;
    end else begin
      grant = req_valid[1];
    end

    case (state)
      ST_IDLE: begin
        if (grant_any) begin
          req_ready = grant ? 2'b10 : 2'b01;
          req_fire  = 1'b1;
          state_nxt = ST_EXEC;
        end
      end
      ST_EXEC: begin
        state_nxt = ST_RESP;
      end
      ST_RESP: begin
        // Only the owner's rsp_ready matters; the other bit is ignored.
        if (rsp_ready[grant_id]) begin
          rsp_fire  = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Grant bookkeeping; last_grant resets to 1 so requester 0 wins the first tie
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
      grant_id   <= 1'b0;
    end else if (req_fire) begin
      last_grant <= grant;
      grant_id   <= grant;
    end
  end

  // ALU drive registers: loaded only on a request handshake and otherwise
  // left alone so the shared ALU never sees idle-time toggling.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a   <= '0;
      alu_b   <= '0;
      alu_c   <= 3'b000;
      alu_cin <= 1'b0;
    end else if (req_fire) begin
      if (grant) begin
        alu_a   <= req1_a;
        alu_b   <= req1_b;
        alu_c   <= req1_op;
        alu_cin <= req1_cin;
      end else begin
        alu_a   <= req0_a;
        alu_b   <= req0_b;
        alu_c   <= req0_op;
        alu_cin <= req0_cin;
      end
    end
  end

  // Response capture at the end of EXEC; held until the owner accepts
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 2'b00;
      rsp_f     <= '0;
      rsp_flags <= 3'b000;
    end else if (state == ST_EXEC) begin
      rsp_valid <= grant_id ? 2'b10 : 2'b01;
      rsp_f     <= alu_f;
      rsp_flags <= {alu_cout, alu_v, alu_z};
    end else if (rsp_fire) begin
      rsp_valid <= 2'b00;
    end
  end

  assign busy = (state != ST_IDLE);

`ifdef ALU_SHARE_OPCOUNT_EN
  // Completed-op counter (wraps naturally) and per-requester toggle bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_count     <= 16'h0000;
      op_count_sel <= 2'b00;
    end else if (rsp_fire) begin
      op_count     <= op_count + 16'd1;
      op_count_sel <= op_count_sel ^ (grant_id ? 2'b10 : 2'b01);
    end
  end
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb/tb_alu_share_arbiter.sv - self-checking bench for alu_share_arbiter
module tb_alu_share_arbiter;

  logic       clk;
  logic       rst_n;
  logic [1:0] req_valid;
  logic [1:0] req_ready;
  logic [3:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0] req0_op, req1_op;
  logic       req0_cin, req1_cin;
  logic [1:0] rsp_valid;
  logic [1:0] rsp_ready;
  logic [3:0] rsp_f;
  logic [2:0] rsp_flags;
  logic [3:0] alu_a, alu_b;
  logic [2:0] alu_c;
  logic       alu_cin;
  logic [3:0] alu_f;
  logic       alu_cout, alu_v, alu_z;
  logic       busy;
`ifdef ALU_SHARE_OPCOUNT_EN
  logic [15:0] op_count;
  logic [1:0]  op_count_sel;
`endif

  int pass_cnt;
  int total_cnt;
  logic [7:0] sb[$];   // {id, f[3:0], cout, v, z}
  logic [7:0] exp_w;
  logic [7:0] act_w;

  alu_share_arbiter #(.N(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op), .req0_cin(req0_cin),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op), .req1_cin(req1_cin),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_f(rsp_f), .rsp_flags(rsp_flags),
    .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c), .alu_cin(alu_cin),
    .alu_f(alu_f), .alu_cout(alu_cout), .alu_v(alu_v), .alu_z(alu_z),
    .busy(busy)
`ifdef ALU_SHARE_OPCOUNT_EN
    ,
    .op_count(op_count), .op_count_sel(op_count_sel)
`endif
  );

  function automatic logic [6:0] alu_model(input logic [3:0] a, input logic [3:0] b,
                                           input logic cin);
    logic [4:0] s;
    logic [3:0] f;
    logic       v;
    s = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
    f = s[3:0];
    v = (a[3] == b[3]) && (f[3] != a[3]);
    return {f, s[4], v, (f == 4'h0)};
  endfunction

  assign {alu_f, alu_cout, alu_v, alu_z} = alu_model(alu_a, alu_b, alu_cin);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push_exp(input logic id, input logic [3:0] a, input logic [3:0] b,
                          input logic cin);
    sb.push_back({id, alu_model(a, b, cin)});
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    req_valid = 2'b00; rsp_ready = 2'b00;
    req0_a = 4'h0; req0_b = 4'h0; req0_op = 3'b000; req0_cin = 1'b0;
    req1_a = 4'h0; req1_b = 4'h0; req1_op = 3'b000; req1_cin = 1'b0;
    #1;
    total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else pass_cnt++;
    total_cnt++; if (rsp_valid !== 2'b00) $display("FAIL reset_rsp_valid got %b want 00", rsp_valid); else pass_cnt++;
    total_cnt++; if ({alu_a, alu_b, alu_c, alu_cin} !== 12'h000)
      $display("FAIL reset_alu_regs got %h want 000", {alu_a, alu_b, alu_c, alu_cin}); else pass_cnt++;
    total_cnt++; if ({rsp_f, rsp_flags} !== 7'h00)
      $display("FAIL reset_rsp_data got %h want 00", {rsp_f, rsp_flags}); else pass_cnt++;
    total_cnt++; if (req_ready !== 2'b00) $display("FAIL reset_req_ready got %b want 00", req_ready); else pass_cnt++;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single;
    @(negedge clk);
    req_valid = 2'b01; req0_a = 4'h3; req0_b = 4'h4; req0_op = 3'b010; req0_cin = 1'b0;
    rsp_ready = 2'b01;
    #1;
    total_cnt++; if (req_ready !== 2'b01) $display("FAIL single_req_ready got %b want 01", req_ready); else pass_cnt++;
    push_exp(1'b0, 4'h3, 4'h4, 1'b0);
    @(negedge clk);
    req_valid = 2'b00;
    #1;
    total_cnt++; if (busy !== 1'b1) $display("FAIL single_exec_busy got %b want 1", busy); else pass_cnt++;
    total_cnt++; if ({alu_a, alu_b, alu_c, alu_cin} !== {4'h3, 4'h4, 3'b010, 1'b0})
      $display("FAIL single_alu_drive got %h want %h", {alu_a, alu_b, alu_c, alu_cin}, {4'h3, 4'h4, 3'b010, 1'b0});
    else pass_cnt++;
    total_cnt++; if (rsp_valid !== 2'b00) $display("FAIL single_exec_rsp_valid got %b want 00", rsp_valid); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (rsp_valid !== 2'b01) $display("FAIL single_rsp_valid got %b want 01", rsp_valid); else pass_cnt++;
    total_cnt++; if ({rsp_f, rsp_flags} !== {4'h7, 3'b000})
      $display("FAIL single_rsp_data got %h want %h", {rsp_f, rsp_flags}, {4'h7, 3'b000}); else pass_cnt++;
    total_cnt++;
    if (sb.size() == 0) $display("FAIL single_sb got empty want entry");
    else begin
      exp_w = sb.pop_front(); act_w = {rsp_valid[1], rsp_f, rsp_flags};
      if (act_w !== exp_w) $display("FAIL single_sb got %h want %h", act_w, exp_w); else pass_cnt++;
    end
    @(negedge clk);
    total_cnt++; if ({busy, rsp_valid} !== 3'b000)
      $display("FAIL single_back_idle got %b want 000", {busy, rsp_valid}); else pass_cnt++;
    rsp_ready = 2'b00;
  endtask

  task automatic test_overflow;
    req_valid = 2'b10; req1_a = 4'h8; req1_b = 4'h8; req1_op = 3'b001; req1_cin = 1'b0;
    rsp_ready = 2'b10;
    #1;
    total_cnt++; if (req_ready !== 2'b10) $display("FAIL ovf_req_ready got %b want 10", req_ready); else pass_cnt++;
    push_exp(1'b1, 4'h8, 4'h8, 1'b0);
    @(negedge clk);
    req_valid = 2'b00;
    @(negedge clk);
    total_cnt++; if (rsp_valid !== 2'b10) $display("FAIL ovf_rsp_valid got %b want 10", rsp_valid); else pass_cnt++;
    total_cnt++; if ({rsp_f, rsp_flags} !== {4'h0, 3'b111})
      $display("FAIL ovf_rsp_data got %h want %h", {rsp_f, rsp_flags}, {4'h0, 3'b111}); else pass_cnt++;
    total_cnt++;
    if (sb.size() == 0) $display("FAIL ovf_sb got empty want entry");
    else begin
      exp_w = sb.pop_front(); act_w = {rsp_valid[1], rsp_f, rsp_flags};
      if (act_w !== exp_w) $display("FAIL ovf_sb got %h want %h", act_w, exp_w); else pass_cnt++;
    end
    @(negedge clk);
    rsp_ready = 2'b00;
  endtask

  task automatic test_tie;
    logic       exp_last;
    logic       g;
    logic [3:0] ea;
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    sb.delete();
    exp_last = 1'b1;
    req_valid = 2'b11; rsp_ready = 2'b11;
    for (int k = 0; k < 4; k++) begin
      req0_a = 4'($urandom_range(15)); req0_b = 4'($urandom_range(15)); req0_cin = 1'($urandom_range(1));
      req1_a = 4'($urandom_range(15)); req1_b = 4'($urandom_range(15)); req1_cin = 1'($urandom_range(1));
      #1;
      g = ~exp_last;
      exp_last = g;
      ea = g ? req1_a : req0_a;
      total_cnt++; if (req_ready !== (g ? 2'b10 : 2'b01))
        $display("FAIL tie_grant_%0d got %b want %b", k, req_ready, (g ? 2'b10 : 2'b01)); else pass_cnt++;
      if (g) push_exp(1'b1, req1_a, req1_b, req1_cin);
      else   push_exp(1'b0, req0_a, req0_b, req0_cin);
      @(negedge clk);
      total_cnt++; if (alu_a !== ea) $display("FAIL tie_alu_a_%0d got %h want %h", k, alu_a, ea); else pass_cnt++;
      @(negedge clk);
      total_cnt++; if (rsp_valid !== (g ? 2'b10 : 2'b01))
        $display("FAIL tie_rsp_valid_%0d got %b want %b", k, rsp_valid, (g ? 2'b10 : 2'b01)); else pass_cnt++;
      total_cnt++;
      if (sb.size() == 0) $display("FAIL tie_sb_%0d got empty want entry", k);
      else begin
        exp_w = sb.pop_front(); act_w = {rsp_valid[1], rsp_f, rsp_flags};
        if (act_w !== exp_w) $display("FAIL tie_sb_%0d got %h want %h", k, act_w, exp_w); else pass_cnt++;
      end
      @(negedge clk);
    end
    req_valid = 2'b00; rsp_ready = 2'b00;
  endtask

  task automatic test_backpressure;
    @(negedge clk);
    req_valid = 2'b01; req0_a = 4'h5; req0_b = 4'h6; req0_cin = 1'b1; rsp_ready = 2'b00;
    #1;
    push_exp(1'b0, 4'h5, 4'h6, 1'b1);
    @(negedge clk);
    req_valid = 2'b11;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      #1;
      total_cnt++; if ({rsp_valid, rsp_f, rsp_flags} !== {2'b01, 4'hC, 3'b010})
        $display("FAIL bp_hold_%0d got %h want %h", i, {rsp_valid, rsp_f, rsp_flags}, {2'b01, 4'hC, 3'b010});
      else pass_cnt++;
      total_cnt++; if ({req_ready, busy} !== 3'b001)
        $display("FAIL bp_ready_busy_%0d got %b want 001", i, {req_ready, busy}); else pass_cnt++;
      @(negedge clk);
    end
    rsp_ready = 2'b10;
    @(negedge clk);
    total_cnt++; if (rsp_valid !== 2'b01) $display("FAIL bp_wrong_ready got %b want 01", rsp_valid); else pass_cnt++;
    req_valid = 2'b00; rsp_ready = 2'b01;
    total_cnt++;
    if (sb.size() == 0) $display("FAIL bp_sb got empty want entry");
    else begin
      exp_w = sb.pop_front(); act_w = {rsp_valid[1], rsp_f, rsp_flags};
      if (act_w !== exp_w) $display("FAIL bp_sb got %h want %h", act_w, exp_w); else pass_cnt++;
    end
    @(negedge clk);
    total_cnt++; if ({busy, rsp_valid} !== 3'b000)
      $display("FAIL bp_release got %b want 000", {busy, rsp_valid}); else pass_cnt++;
    rsp_ready = 2'b00;
  endtask

  task automatic test_reset_mid;
    req_valid = 2'b01; req0_a = 4'h9; req0_b = 4'h2; req0_op = 3'b101; req0_cin = 1'b1;
    rsp_ready = 2'b01;
    @(negedge clk);
    req_valid = 2'b00;
    rst_n = 1'b0;
    #1;
    total_cnt++; if ({busy, rsp_valid, req_ready} !== 5'b00000)
      $display("FAIL mid_rst_ctrl got %b want 00000", {busy, rsp_valid, req_ready}); else pass_cnt++;
    total_cnt++; if ({alu_a, alu_b, alu_c, alu_cin, rsp_f, rsp_flags} !== 19'h0)
      $display("FAIL mid_rst_data got %h want 0", {alu_a, alu_b, alu_c, alu_cin, rsp_f, rsp_flags}); else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    sb.delete();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      total_cnt++; if (rsp_valid !== 2'b00) $display("FAIL mid_no_rsp_%0d got %b want 00", i, rsp_valid); else pass_cnt++;
    end
    req_valid = 2'b11; req0_a = 4'h1; req0_b = 4'h1; req0_cin = 1'b0;
    req1_a = 4'h7; req1_b = 4'h7; req1_cin = 1'b0;
    #1;
    total_cnt++; if (req_ready !== 2'b01) $display("FAIL mid_tie_grant got %b want 01", req_ready); else pass_cnt++;
    push_exp(1'b0, 4'h1, 4'h1, 1'b0);
    @(negedge clk);
    req_valid = 2'b00;
    @(negedge clk);
    total_cnt++;
    if (sb.size() == 0) $display("FAIL mid_sb got empty want entry");
    else begin
      exp_w = sb.pop_front(); act_w = {rsp_valid[1], rsp_f, rsp_flags};
      if (rsp_valid !== 2'b01 || act_w !== exp_w)
        $display("FAIL mid_sb got %b/%h want 01/%h", rsp_valid, act_w, exp_w); else pass_cnt++;
    end
    @(negedge clk);
    rsp_ready = 2'b00;
  endtask

`ifdef ALU_SHARE_OPCOUNT_EN
  task automatic test_opcount;
    @(negedge clk); rst_n = 1'b0;
    #1;
    total_cnt++; if (op_count !== 16'd0) $display("FAIL cnt_reset got %0d want 0", op_count); else pass_cnt++;
    @(negedge clk); rst_n = 1'b1;
    rsp_ready = 2'b11;
    for (int k = 0; k < 3; k++) begin
      req_valid = (k == 1) ? 2'b10 : 2'b01;
      @(negedge clk); req_valid = 2'b00;
      @(negedge clk);
      @(negedge clk);
    end
    total_cnt++; if (op_count !== 16'd3) $display("FAIL cnt_three got %0d want 3", op_count); else pass_cnt++;
    total_cnt++; if (op_count_sel !== 2'b10) $display("FAIL cnt_sel got %b want 10", op_count_sel); else pass_cnt++;
    rsp_ready = 2'b00;
  endtask
`endif

  initial begin
    pass_cnt = 0;
    total_cnt = 0;
    test_reset();
    test_single();
    test_overflow();
    test_tie();
    test_backpressure();
    test_reset_mid();
`ifdef ALU_SHARE_OPCOUNT_EN
    test_opcount();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
